// File: rtl/div_seq_32bit.sv
// Iterative restoring divider for MIPS DIV/DIVU: one subtract-and-shift step per clock,
// a sign-fixup cycle, and a one-cycle fast path for a zero divisor.
module div_seq_32bit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [1:0]       o_dbg_state
);

   localparam int CW = $clog2(WIDTH + 1);

   // Handshake: start is sampled only while IDLE. busy is high in every cycle from the
   // acceptance edge up to the edge that raises done; done is a one-cycle pulse and the
   // results stay valid until the next accepted start.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIX   = 2'd2,
      S_DZERO = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_pr;
   logic [WIDTH-1:0] r_dmag;
   logic [WIDTH-1:0] r_dividend;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [CW-1:0]    r_cnt;
   logic             r_done;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dz;

   logic             w_accept;
   logic             w_step;
   logic             w_fix;
   logic             w_dzero;
   logic             w_busy;
   logic             w_div_zero;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = w_div_zero ? S_DZERO : S_CALC;
            end
         end
         S_CALC: begin
            if (r_cnt == CW'(1)) begin
               w_state_nxt = S_FIX;
            end
         end
         S_FIX:   w_state_nxt = S_IDLE;
         S_DZERO: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- output / control decode ----------------
   always_comb begin
      w_accept = 1'b0;
      w_step   = 1'b0;
      w_fix    = 1'b0;
      w_dzero  = 1'b0;
      w_busy   = 1'b0;
      case (r_state)
         S_IDLE:  w_accept = start;
         S_CALC: begin
            w_step = 1'b1;
            w_busy = 1'b1;
         end
         S_FIX: begin
            w_fix  = 1'b1;
            w_busy = 1'b1;
         end
         S_DZERO: begin
            w_dzero = 1'b1;
            w_busy  = 1'b1;
         end
         default: w_busy = 1'b0;
      endcase
   end

   // ---------------- datapath ----------------
   assign w_div_zero = (divisor == '0);
   assign w_a_mag    = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign w_b_mag    = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

   // The partial remainder is always below the divisor, so WIDTH bits hold it;
   // only the shifted trial value needs the extra bit.
   assign w_shift = {r_pr, r_q[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_dmag};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q        <= '0;
         r_pr       <= '0;
         r_dmag     <= '0;
         r_dividend <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_cnt      <= '0;
      end else if (w_accept) begin
         r_q        <= w_a_mag;
         r_pr       <= '0;
         r_dmag     <= w_b_mag;
         r_dividend <= dividend;
         r_neg_q    <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         r_neg_r    <= div_signed & dividend[WIDTH-1];
         r_cnt      <= CW'(WIDTH);
      end else if (w_step) begin
         if (!w_trial[WIDTH]) begin
            r_pr <= w_trial[WIDTH-1:0];
            r_q  <= {r_q[WIDTH-2:0], 1'b1};
         end else begin
            r_pr <= w_shift[WIDTH-1:0];
            r_q  <= {r_q[WIDTH-2:0], 1'b0};
         end
         r_cnt <= r_cnt - CW'(1);
      end
   end

   // Negation wraps, so the signed overflow case yields 0x80000000 with no flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dz        <= 1'b0;
      end else begin
         r_done <= w_fix | w_dzero;
         if (w_accept && !w_div_zero) begin
            r_dz <= 1'b0;
         end
         if (w_fix) begin
            r_quotient  <= r_neg_q ? -r_q  : r_q;
            r_remainder <= r_neg_r ? -r_pr : r_pr;
         end
         if (w_dzero) begin
            r_quotient  <= '1;
            r_remainder <= r_dividend;
            r_dz        <= 1'b1;
         end
      end
   end

   assign busy        = w_busy;
   assign done        = r_done;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dz;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_seq_32bit.sv
// Randomized self-checking bench for div_seq_32bit against a plain-arithmetic reference.
module tb_div_seq_32bit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         div_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // expected {div_by_zero, quotient, remainder}
  logic [2*W:0] exp_q[$];

  div_seq_32bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .div_signed  (div_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: C-style truncating division; zero divisor gives all ones / dividend.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    longint sa, sb, lq, lr;
    logic [W-1:0] q, r;
    if (b == 0) return {1'b1, {W{1'b1}}, a};
    if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q = lq[W-1:0];
      r = lr[W-1:0];
    end
    return {1'b0, q, r};
  endfunction

  // ---------------- driver ----------------
  // Called just after a clock edge; returns just after the acceptance edge.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    dividend   = a;
    divisor    = b;
    div_signed = s;
    start      = 1'b1;
    exp_q.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    start      = 1'b0;
    dividend   = $urandom;
    divisor    = $urandom;
    div_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int exp_lat, input string tag, input bit chk_hold);
    int n = 0;
    bit seen = 0;
    bit gap = 0;
    logic [2*W:0] e;
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1;
      else if (!busy) gap = 1;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_busy_gap"}, 64'(gap), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_quotient"}, 64'(quotient), 64'(e[2*W-1:W]));
    check({tag, "_remainder"}, 64'(remainder), 64'(e[W-1:0]));
    check({tag, "_dz"}, 64'(div_by_zero), 64'(e[2*W]));
    if (chk_hold) begin
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_hold_q"}, 64'(quotient), 64'(e[2*W-1:W]));
      check({tag, "_hold_r"}, 64'(remainder), 64'(e[W-1:0]));
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input string tag);
    drive_start(a, b, s);
    wait_done((b == 0) ? 1 : W + 1, tag, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a, b;
    logic         s;
    int           dn;
    rst_n = 1'b0;
    start = 1'b0;
    div_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_r", 64'(remainder), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(32'd100, 32'd7, 1'b0, "u100_7");
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, "s_m7_2");
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, "s_7_m2");
    run_op(32'h00001234, 32'd0, 1'b0, "dz_u");
    run_op(32'h00001234, 32'd0, 1'b1, "dz_s");
    run_op(32'd10, 32'd3, 1'b0, "after_dz");
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, "ovf_s");
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, "ovf_u");

    // start pulsed mid-operation must be ignored
    drive_start(32'd1000, 32'd9, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    dividend = 32'd55; divisor = 32'd0; div_signed = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(W + 1 - 10, "ignore_start", 1'b1);

    // back-to-back: start during the done cycle
    drive_start(32'd500, 32'd25, 1'b0);
    wait_done(W + 1, "b2b_first", 1'b0);
    drive_start(32'hFFFFFF00, 32'd16, 1'b1);
    wait_done(W + 1, "b2b_second", 1'b1);

    // asynchronous reset mid-operation
    drive_start(32'd123456, 32'd789, 1'b0);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_q", 64'(quotient), 64'd0);
    check("mid_rst_r", 64'(remainder), 64'd0);
    check("mid_rst_dz", 64'(div_by_zero), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("mid_rst_no_done", 64'(dn), 64'd0);
    run_op(32'hFFFFFFFF, 32'h10, 1'b0, "post_rst");

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: b = a;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      s = 1'($urandom_range(0, 1));
      run_op(a, b, s, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_seq_32bit.md
Name: div_seq_32bit

Overview:
- Iterative 32-bit integer divider: the division counterpart to the combinational add/sub datapath.
- Performs one restoring subtract-and-shift step per clock, plus one sign-fixup cycle.
- Sits beside the ALU. It serves MIPS DIV/DIVU and feeds the HI (remainder) and LO (quotient) registers.
- Uses a start/busy/done handshake so the pipeline can stall while the block is busy.

Parameters:
- WIDTH, 32, operand and result width in bits. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a divide; sampled only in IDLE.
- div_signed  input  1  0 = unsigned (DIVU), 1 = two's-complement signed (DIV); captured with start.
- dividend  input  WIDTH  numerator; captured when start is accepted.
- divisor  input  WIDTH  denominator; captured when start is accepted.
- busy  output  1  high from the cycle after acceptance until the cycle done is asserted.
- done  output  1  single-cycle pulse; quotient and remainder are valid from this cycle onward.
- quotient  output  WIDTH  LO result.
- remainder  output  WIDTH  HI result.
- div_by_zero  output  1  set with done when the captured divisor was 0; held with the results.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0; iteration counter = 0. An operation in flight is abandoned with no done pulse.
- States: IDLE, CALC, FIX, DZERO.
- IDLE + start=1 at edge E0:
  - Capture operands and div_signed.
  - Record the magnitudes |dividend| and |divisor| (absolute value only when div_signed=1).
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend). Both are forced to 0 when unsigned.
  - Clear the partial remainder (WIDTH+1 bits) and load the quotient shift register with |dividend|. Counter = WIDTH.
  - If divisor == 0, go to DZERO; otherwise go to CALC. busy = 1 after E0.
- CALC, each edge:
  - Shift {partial remainder, quotient register} left 1.
  - Trial subtract (WIDTH+1 bit): partial remainder minus {0,|divisor|}.
  - If the result is non-negative, keep it and set quotient LSB = 1; otherwise restore and set LSB = 0.
  - Decrement the counter. When the counter reaches 1, the next state is FIX.
  - Exactly WIDTH CALC edges (E1..E32 for WIDTH=32).
- FIX (edge E33):
  - quotient = neg_q ? -q_mag : q_mag.
  - remainder = neg_r ? -r_mag : r_mag.
  - done = 1 and busy = 0 for the following cycle; next state is IDLE.
  - Total latency from acceptance edge to done = WIDTH+1 cycles.
- DZERO (edge E1):
  - quotient = all ones, remainder = captured dividend (unmodified), div_by_zero = 1.
  - done = 1, busy = 0; next state is IDLE. Latency is 1 cycle.
- Signed overflow (0x80000000 / 0xFFFFFFFF, signed):
  - Magnitudes are handled as unsigned WIDTH-bit values, giving q_mag = 2^31.
  - Negation wraps, so quotient = 0x80000000 and remainder = 0. No flag is raised.
- Result hold:
  - quotient, remainder and div_by_zero hold their values until the next accepted start.
  - div_by_zero clears on a start that does not divide by zero.
- done is high for exactly one cycle. start in the same cycle as done is accepted, because the state is IDLE at that edge.
- start while busy (CALC/FIX/DZERO) is ignored: the operands are not recaptured and the operation in flight is unaffected.
- Input changes after acceptance have no effect.
- Remainder sign always follows the dividend; |remainder| < |divisor|; dividend = quotient*divisor + remainder (mod 2^WIDTH).

Test Plan:
- Unsigned 100 / 7, start at E0 -> busy high for cycles E1..E33, done at E33 only; quotient = 14, remainder = 2, div_by_zero = 0.
- Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed 7 / 0xFFFFFFFE (-2) -> quotient 0xFFFFFFFD, remainder 1.
- Divide by zero: 0x00001234 / 0 (either mode) -> done after 1 cycle, quotient 0xFFFFFFFF, remainder 0x00001234, div_by_zero = 1. A following 10/3 clears div_by_zero and gives quotient 3, remainder 1.
- Overflow operands 0x80000000 / 0xFFFFFFFF:
  - Signed -> quotient 0x80000000, remainder 0.
  - Unsigned -> quotient 0, remainder 0x80000000.
- Reissue and protection:
  - Pulse start with new operands at E10 of a running op -> ignored; the original result is returned at E33.
  - Back-to-back start at the done cycle -> second op accepted, with done 33 cycles later.
- Reset mid-operation: assert rst_n=0 asynchronously at E15 -> busy, done and outputs go to 0 immediately and no done pulse follows. After release, a 0xFFFFFFFF / 0x10 unsigned op yields quotient 0x0FFFFFFF, remainder 0xF.
